quad_decoder_counter: RTL and testbench

Quadrature (A/B) decoder that turns the two phase inputs from an incremental encoder into up/down step commands. It keeps an N-bit position counter with synchronous parallel load. It sits in front of, and drives, the sync up/down counter path: it generates the direction and count-enable that the counter consumes. It also flags illegal phase jumps.

---
 rtl/quad_decoder_counter.sv | 114 +++++++++++
 tb/tb_quad_decoder_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder driving an N-bit up/down position counter.
// Flags illegal double-bit phase jumps with a sticky error.
module quad_decoder_counter #(
    parameter int unsigned N           = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         load_in,
    input  logic [N-1:0] d_in,
    input  logic         clr_err_in,
    output logic [N-1:0] count_out,
    output logic         up_down_out,
    output logic         step_out,
    output logic         err_out
);

    localparam int unsigned IW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          init_q, init_d;
    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
    logic [1:0]             prev_ab_q, prev_ab_d;
    logic [1:0]             ab;
    logic [1:0]             delta;
    logic [N-1:0]           count_d;
    logic                   up_down_d, step_d, err_d;

    // Gray phase to position: 00->0, 01->1, 11->2, 10->3
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    assign ab    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    assign delta = gray_pos(ab) - gray_pos(prev_ab_q);

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
        end
    end

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        prev_ab_d = ab;
        count_d   = count_out;
        up_down_d = up_down_out;
        step_d    = 1'b0;
        err_d     = err_out;

        if (clr_err_in)
            err_d = 1'b0;

        unique case (state_q)
            INIT: begin
                if (init_q == IW'(SYNC_STAGES))
                    state_d = RUN;
                else
                    init_d = init_q + IW'(1);
            end
            RUN: begin
                unique case (delta)
                    2'd1: begin
                        step_d    = 1'b1;
                        up_down_d = 1'b1;
                        count_d   = count_out + N'(1);
                    end
                    2'd3: begin
                        step_d    = 1'b1;
                        up_down_d = 1'b0;
                        count_d   = count_out - N'(1);
                    end
                    2'd2:    err_d = 1'b1;
                    default: ;
                endcase
            end
            default: state_d = INIT;
        endcase

        // Load overrides only the count; step/direction still report the step.
        if (load_in)
            count_d = d_in;
    end

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q     <= INIT;
            init_q      <= '0;
            prev_ab_q   <= '0;
            count_out   <= '0;
            up_down_out <= 1'b1;
            step_out    <= 1'b0;
            err_out     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            prev_ab_q   <= prev_ab_d;
            count_out   <= count_d;
            up_down_out <= up_down_d;
            step_out    <= step_d;
            err_out     <= err_d;
        end
    end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Scoreboard bench for quad_decoder_counter: stimulus queues expected steps,
// a negedge monitor matches them against step_out pulses.
module tb_quad_decoder_counter;

    logic       clk = 1'b0;
    logic       reset_al_in;
    logic       a_in, b_in;
    logic       load_in;
    logic [2:0] d_in;
    logic       clr_err_in;
    logic [2:0] count_out;
    logic       up_down_out;
    logic       step_out;
    logic       err_out;

    typedef struct {
        logic [2:0] cnt;
        logic       dir;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    quad_decoder_counter #(.N(3), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .a_in        (a_in),
        .b_in        (b_in),
        .load_in     (load_in),
        .d_in        (d_in),
        .clr_err_in  (clr_err_in),
        .count_out   (count_out),
        .up_down_out (up_down_out),
        .step_out    (step_out),
        .err_out     (err_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endfunction

    // Monitor: every step pulse must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (step_out) begin
            if (exp_q.size() == 0) begin
                check("step_unexpected", 32'(step_out), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("step_count", 32'(count_out), 32'(e.cnt));
                check("step_dir", 32'(up_down_out), 32'(e.dir));
                check("step_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("step_missing", 32'(step_out), 32'd1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic phase(input logic [1:0] ab, input bit stepped, input logic [2:0] cnt, input logic dir);
        {a_in, b_in} = ab;
        if (stepped)
            exp_q.push_back('{cnt: cnt, dir: dir, cyc: cyc + 3});
        tick(4);
    endtask

    task automatic do_load(input logic [2:0] v);
        load_in = 1'b1;
        d_in    = v;
        tick(1);
        load_in = 1'b0;
        check("load_value", 32'(count_out), 32'(v));
    endtask

    logic [1:0] fwd_seq [9] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [2:0] fwd_cnt [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [1:0] bwd_seq [8] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [2:0] bwd_cnt [8] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};

    initial begin
        reset_al_in = 1'b0;
        {a_in, b_in} = 2'b11;
        load_in    = 1'b0;
        d_in       = '0;
        clr_err_in = 1'b0;
        tick(2);
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_dir", 32'(up_down_out), 32'd1);
        check("rst_step", 32'(step_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);

        // Inputs parked at 11 through INIT: no step, no error
        reset_al_in = 1'b1;
        tick(6);
        check("init_count", 32'(count_out), 32'd0);
        check("init_dir", 32'(up_down_out), 32'd1);
        check("init_err", 32'(err_out), 32'd0);

        phase(2'b10, 1'b1, 3'd1, 1'b1);
        phase(2'b00, 1'b1, 3'd2, 1'b1);

        do_load(3'd0);
        for (int i = 0; i < 9; i++)
            phase(fwd_seq[i], 1'b1, fwd_cnt[i], 1'b1);

        do_load(3'd6);
        for (int i = 0; i < 8; i++)
            phase(bwd_seq[i], 1'b1, bwd_cnt[i], 1'b0);

        phase(2'b00, 1'b1, 3'd5, 1'b0);
        check("err_before_jump", 32'(err_out), 32'd0);
        phase(2'b11, 1'b0, 3'd0, 1'b0);
        check("err_set", 32'(err_out), 32'd1);
        check("err_count_hold", 32'(count_out), 32'd5);
        check("err_dir_hold", 32'(up_down_out), 32'd0);
        phase(2'b01, 1'b1, 3'd4, 1'b0);

        // Clear coincides with a new 01->10 jump: error must stay set
        {a_in, b_in} = 2'b10;
        tick(2);
        clr_err_in = 1'b1;
        tick(1);
        clr_err_in = 1'b0;
        tick(1);
        check("err_clr_vs_jump", 32'(err_out), 32'd1);
        check("err_jump_count", 32'(count_out), 32'd4);
        clr_err_in = 1'b1;
        tick(1);
        clr_err_in = 1'b0;
        check("err_cleared", 32'(err_out), 32'd0);
        tick(2);

        // Load lands in the same cycle a forward step resolves
        {a_in, b_in} = 2'b00;
        exp_q.push_back('{cnt: 3'd2, dir: 1'b1, cyc: cyc + 3});
        tick(2);
        load_in = 1'b1;
        d_in    = 3'd2;
        tick(1);
        load_in = 1'b0;
        tick(1);
        check("load_step_count", 32'(count_out), 32'd2);

        phase(2'b01, 1'b1, 3'd3, 1'b1);
        phase(2'b11, 1'b1, 3'd4, 1'b1);
        phase(2'b10, 1'b1, 3'd5, 1'b1);
        check("pre_reset_count", 32'(count_out), 32'd5);

        #2;
        reset_al_in = 1'b0;
        #1;
        check("async_rst_count", 32'(count_out), 32'd0);
        check("async_rst_dir", 32'(up_down_out), 32'd1);
        check("async_rst_step", 32'(step_out), 32'd0);
        check("async_rst_err", 32'(err_out), 32'd0);
        tick(2);
        reset_al_in = 1'b1;
        tick(6);
        check("reinit_count", 32'(count_out), 32'd0);
        check("reinit_err", 32'(err_out), 32'd0);

        phase(2'b00, 1'b1, 3'd1, 1'b1);
        phase(2'b01, 1'b1, 3'd2, 1'b1);
        tick(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
